// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : Two-master to one-slave arbiter for an SRAM-like bus.
//               The data master has fixed priority over the instruction
//               master. A grant that is waiting for m_addr_ok is held until
//               it is accepted or its master withdraws. An ordered id FIFO
//               records who owns each outstanding transaction, so every
//               m_data_ok goes back to the master that issued it.
// Ports       : clk, resetn          - clock, asynchronous active-low reset
//               inst_* / data_*      - master request fields and responses
//               m_*                  - shared slave request and responses
//               err                  - sticky flag: m_data_ok with nothing
//                                      outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        err
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    // Source id FIFO: 0 = instruction master, 1 = data master.
    logic [DEPTH-1:0]   r_fifo_id;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               r_hold_valid;
    logic               r_hold_id;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_grant_inst;
    logic               w_grant_data;
    logic               w_push;
    logic               w_pop;
    logic               w_head_id;

    assign w_full    = (r_count == c_FULL);
    assign w_empty   = (r_count == '0);
    assign w_head_id = r_fifo_id[r_rd_ptr];

    // Fixed priority with a hold override. The hold only applies while the
    // held master still requests; otherwise arbitration starts fresh. The
    // resetn term keeps m_req low for the whole time reset is asserted, since
    // the requests themselves are not under reset control.
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        if (resetn && !w_full) begin
            if (r_hold_valid && !r_hold_id && inst_req) begin
                w_grant_inst = 1'b1;
            end else if (r_hold_valid && r_hold_id && data_req) begin
                w_grant_data = 1'b1;
            end else if (data_req) begin
                w_grant_data = 1'b1;
            end else if (inst_req) begin
                w_grant_inst = 1'b1;
            end
        end
    end

    assign m_req  = w_grant_inst | w_grant_data;
    assign w_push = m_req & m_addr_ok;
    // A response with nothing outstanding is dropped and flagged instead.
    assign w_pop  = m_data_ok & !w_empty;

    always_comb begin
        m_wr    = 1'b0;
        m_size  = '0;
        m_addr  = '0;
        m_wstrb = '0;
        m_wdata = '0;
        if (w_grant_data) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_addr  = data_addr;
            m_wstrb = data_wstrb;
            m_wdata = data_wdata;
        end else if (w_grant_inst) begin
            m_wr    = inst_wr;
            m_size  = inst_size;
            m_addr  = inst_addr;
            m_wstrb = inst_wstrb;
            m_wdata = inst_wdata;
        end
    end

    assign inst_addr_ok = m_addr_ok & w_grant_inst;
    assign data_addr_ok = m_addr_ok & w_grant_data;
    assign inst_data_ok = w_pop & !w_head_id;
    assign data_data_ok = w_pop &  w_head_id;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign err          = r_err;

    // Id storage carries no reset; only the pointers and count define which
    // entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_id[r_wr_ptr] <= w_grant_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hold_valid <= 1'b0;
            r_hold_id    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Latch whoever is stalled on m_addr_ok; drop the hold on accept
            // or when nobody is granted.
            if (m_req && !m_addr_ok) begin
                r_hold_valid <= 1'b1;
                r_hold_id    <= w_grant_data;
            end else begin
                r_hold_valid <= 1'b0;
            end

            if (m_data_ok && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Self-checking bench for sram_like_arbiter (DEPTH = 4).
//               Vector table plus hand-written sequences; expected response
//               ids are queued as requests are accepted and popped on
//               m_data_ok.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    localparam logic [31:0] c_I_ADDR  = 32'h1000_0040;
    localparam logic [31:0] c_D_ADDR  = 32'h2000_0080;
    localparam logic [31:0] c_I_WDATA = 32'hAAAA_1111;
    localparam logic [31:0] c_D_WDATA = 32'h5555_2222;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        err;

    sram_like_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wstrb   (inst_wstrb),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wstrb      (m_wstrb),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;
    logic sb[$];

    typedef struct {
        logic  ir;
        logic  dr;
        logic  aok;
        logic  dok;
        int    grant;   // 0 none, 1 inst, 2 data
        string name;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, check at the falling edge.
    task automatic cyc(input logic ir, input logic dr, input logic aok, input logic dok,
                       input int g, input string nm);
        logic [31:0] rd;
        logic        id;
        inst_req  = ir;
        data_req  = dr;
        m_addr_ok = aok;
        m_data_ok = dok;
        rd        = $urandom;
        m_rdata   = rd;
        #4;
        chk({nm, ":m_req"}, 32'(m_req), 32'(g != 0));
        chk({nm, ":m_addr"}, m_addr, (g == 2) ? c_D_ADDR : (g == 1) ? c_I_ADDR : 32'h0);
        chk({nm, ":m_wdata"}, m_wdata, (g == 2) ? c_D_WDATA : (g == 1) ? c_I_WDATA : 32'h0);
        chk({nm, ":m_wr"}, 32'(m_wr), 32'(g == 2));
        chk({nm, ":m_size"}, 32'(m_size), (g == 2) ? 32'd1 : (g == 1) ? 32'd2 : 32'd0);
        chk({nm, ":inst_addr_ok"}, 32'(inst_addr_ok), 32'(g == 1 && aok));
        chk({nm, ":data_addr_ok"}, 32'(data_addr_ok), 32'(g == 2 && aok));
        chk({nm, ":inst_rdata"}, inst_rdata, rd);
        chk({nm, ":data_rdata"}, data_rdata, rd);
        chk({nm, ":err"}, 32'(err), 32'(exp_err));
        if (dok && sb.size() > 0) begin
            id = sb.pop_front();
            chk({nm, ":inst_data_ok"}, 32'(inst_data_ok), 32'(!id));
            chk({nm, ":data_data_ok"}, 32'(data_data_ok), 32'(id));
        end else begin
            chk({nm, ":inst_data_ok"}, 32'(inst_data_ok), 32'd0);
            chk({nm, ":data_data_ok"}, 32'(data_data_ok), 32'd0);
            if (dok) exp_err = 1'b1;
        end
        if (g != 0 && aok) sb.push_back(g == 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        inst_req   = 1'b0;  data_req   = 1'b0;
        m_addr_ok  = 1'b0;  m_data_ok  = 1'b0;  m_rdata = '0;
        inst_wr    = 1'b0;  inst_size  = 2'd2;  inst_addr = c_I_ADDR;
        inst_wstrb = 4'hF;  inst_wdata = c_I_WDATA;
        data_wr    = 1'b1;  data_size  = 2'd1;  data_addr = c_D_ADDR;
        data_wstrb = 4'h3;  data_wdata = c_D_WDATA;

        tbl = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, 0, "idle"},
            '{1'b1, 1'b0, 1'b1, 1'b0, 1, "inst_only"},
            '{1'b0, 1'b1, 1'b1, 1'b0, 2, "data_only"},
            '{1'b1, 1'b1, 1'b1, 1'b0, 2, "both_data_wins"},
            '{1'b1, 1'b1, 1'b0, 1'b0, 2, "both_stall"},
            '{1'b1, 1'b1, 1'b1, 1'b0, 2, "both_held_accept"},
            '{1'b0, 1'b0, 1'b1, 1'b1, 0, "pop_1"},
            '{1'b0, 1'b0, 1'b0, 1'b1, 0, "pop_2"},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1, "push_and_pop"},
            '{1'b0, 1'b0, 1'b0, 1'b1, 0, "pop_3"},
            '{1'b0, 1'b0, 1'b0, 1'b1, 0, "pop_4"}
        };

        // Reset state: requests present but nothing may be granted.
        @(posedge clk);
        #1;
        inst_req  = 1'b1;
        data_req  = 1'b1;
        m_addr_ok = 1'b1;
        #1;
        chk("rst:m_req", 32'(m_req), 32'd0);
        chk("rst:data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst:err", 32'(err), 32'd0);
        chk("rst:count", 32'(dut.r_count), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        foreach (tbl[i]) cyc(tbl[i].ir, tbl[i].dr, tbl[i].aok, tbl[i].dok, tbl[i].grant, tbl[i].name);
        chk("tbl:count", 32'(dut.r_count), 32'd0);

        // Hold: stalled inst keeps the grant even after data requests.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, "hold_c1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1, "hold_c2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1, "hold_c3");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1, "hold_accept");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 2, "hold_data_next");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "hold_pop_1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "hold_pop_2");

        // Hold release when the held master withdraws.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, "rel_c1");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2, "rel_c2");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 2, "rel_c3");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "rel_pop");

        // Fill to DEPTH, blocked fifth request, ordered drain.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, "fill_0");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2, "fill_1");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2, "fill_2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, "fill_3");
        chk("full:count", 32'(dut.r_count), 32'd4);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, "fifth_blocked");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "drain");
        chk("drain:count", 32'(dut.r_count), 32'd0);

        // Full with a pop and a request in the same cycle.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, "refill_0");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2, "refill_1");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, "refill_2");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2, "refill_3");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 0, "full_pop_req");
        chk("full_pop:count", 32'(dut.r_count), 32'd3);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, "grant_after_pop");
        chk("regrant:count", 32'(dut.r_count), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "drain2");

        // Spurious response sets err, which persists until reset.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "empty_dok");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "err_set");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, "err_sticky");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "err_pop");
        resetn = 1'b0;
        #1;
        chk("err_rst:err", 32'(err), 32'd0);
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Asynchronous reset with two outstanding transactions.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1, "out_0");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2, "out_1");
        inst_req  = 1'b1;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        chk("async_rst:count", 32'(dut.r_count), 32'd0);
        chk("async_rst:m_req", 32'(m_req), 32'd0);
        sb.delete();
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, "late_dok");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, "late_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the maximum number of accepted-but-unanswered transactions (power of 2, range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports inst_req/inst_wr, input, 1 bit each: instruction master request and write flag.
REQ-005 The block SHALL have ports inst_size input 2, inst_addr input 32, inst_wstrb input 4, inst_wdata input 32: instruction master request fields.
REQ-006 The block SHALL have ports inst_addr_ok/inst_data_ok, output, 1 bit each, and inst_rdata, output, 32 bits: responses to the instruction master.
REQ-007 The block SHALL have ports data_req/data_wr, input, 1 bit each: data master request and write flag.
REQ-008 The block SHALL have ports data_size input 2, data_addr input 32, data_wstrb input 4, data_wdata input 32: data master request fields.
REQ-009 The block SHALL have ports data_addr_ok/data_data_ok, output, 1 bit each, and data_rdata, output, 32 bits: responses to the data master.
REQ-010 The block SHALL have ports m_req/m_wr output 1, m_size output 2, m_addr output 32, m_wstrb output 4, m_wdata output 32: the shared slave request.
REQ-011 The block SHALL have ports m_addr_ok/m_data_ok, input, 1 bit each, and m_rdata, input, 32 bits: shared slave responses.
REQ-012 The block SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 The block SHALL keep an ordered source FIFO (DEPTH entries, 1-bit id: 0=inst, 1=data) with wrapping read/write pointers and a count in 0..DEPTH.
REQ-014 The block SHALL define full as count==DEPTH; no grant is issued while full, even if a pop occurs in the same cycle.
REQ-015 Arbitration SHALL be fixed priority, data over inst, evaluated combinationally in the same cycle as the request (zero added latency).
REQ-016 The block SHALL have a hold register: when m_req=1 and m_addr_ok=0, it latches the granted id, and the next cycles grant that same master, regardless of priority, until m_addr_ok=1.
REQ-017 The hold register SHALL be released if the held master deasserts its req; arbitration then restarts fresh.
REQ-018 m_req SHALL equal granted master's req, and is 0 when neither master requests or when full.
REQ-019 m_wr/m_size/m_addr/m_wstrb/m_wdata SHALL be muxed from the granted master.
REQ-020 inst_addr_ok SHALL be m_addr_ok & grant_inst, and data_addr_ok SHALL be m_addr_ok & grant_data; the non-granted master never sees addr_ok.
REQ-021 On m_req & m_addr_ok the block SHALL push the granted id at the FIFO tail.
REQ-022 On m_data_ok with count>0 the block SHALL pop the head and pulse the head id's *_data_ok combinationally in that cycle.
REQ-023 inst_rdata and data_rdata SHALL both be driven by m_rdata unconditionally.
REQ-024 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 m_data_ok with count==0 SHALL produce no *_data_ok, and err SHALL set to 1 and stay set until reset.
REQ-026 Responses SHALL be returned strictly in acceptance order; per-master order follows from this.

Reset
REQ-027 On resetn=0 the block SHALL immediately clear count, pointers, hold and err to 0.
REQ-028 During reset all outputs derived from state SHALL read 0; m_req SHALL be 0 while resetn=0.
REQ-029 Transactions outstanding at reset SHALL be discarded; any later m_data_ok for them sets err per REQ-025.

Verification
REQ-030 Both inst_req=1 and data_req=1, m_addr_ok=1 -> m_addr=data_addr, only data_addr_ok=1, FIFO head id=1.
REQ-031 inst_req held alone, m_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> grant stays inst until m_addr_ok; data granted in the following cycle.
REQ-032 Issue 4 accepted requests (ids 0,1,1,0) with DEPTH=4 -> 5th request sees m_req=0; 4 m_data_ok pulses -> inst,data,data,inst data_ok order; count returns to 0.
REQ-033 Full FIFO, m_data_ok and a new request in the same cycle -> no grant that cycle; grant on the next cycle; count 4->3->4.
REQ-034 m_data_ok=1 with empty FIFO -> no *_data_ok, err=1 and it persists; resetn pulse low -> err=0.
REQ-035 Assert resetn=0 asynchronously with 2 outstanding -> count=0 and m_req=0 before the next clk edge.
